// File: rtl/mealy_link_sched.sv
// Purpose: round-robin arbiter that serializes one requester's W-bit word onto a shared S/D decoder link and returns the decoder's Y.
// Latency: 1 cycle from grant decision to first S bit; W+3 cycles minimum IDLE-to-IDLE; R wait bounded by TMO cycles.
// Backpressure: requests wait while the link is busy or the decoder reports non-idle (DecQ != 0); losers stay pending.
//
// Ports:
//   C, aR              clock (rising edge) and synchronous active-high reset
//   Req, Word          per-requester request level and flattened W-bit words (requester i at [i*W +: W])
//   Gnt, Done          one-hot grant (SHIFT through DONE) and one-cycle completion pulse
//   Result, Err        captured Y (held until next capture) and timeout flag (valid with Done)
//   SOut, DOut         serial strobe and MSB-first data to the decoder
//   RIn, YIn, DecQ     decoder R pulse, Y output and state (0 = idle)
//   DecClr             decoder reset request; Busy high whenever not IDLE
module mealy_link_sched #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int TMO  = 8
) (
    input  logic              C,
    input  logic              aR,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ*W-1:0] Word,
    output logic [NREQ-1:0]   Gnt,
    output logic [NREQ-1:0]   Done,
    output logic              Result,
    output logic              Err,
    output logic              SOut,
    output logic              DOut,
    input  logic              RIn,
    input  logic              YIn,
    input  logic [1:0]        DecQ,
    output logic              DecClr,
    output logic              Busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        TERM,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gIdx;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   cnt;
    logic [7:0]      tmo;
    logic            decClrQ;

    logic            winFound;
    logic [PW-1:0]   winIdx;
    logic [PW-1:0]   candIdx;
    logic [W-1:0]    words [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            words[i] = Word[i*W +: W];
        end
    end

    // Rotating priority: the search begins just after the last completed winner,
    // so ptr only moves on a finished transaction (aborts do not consume a turn).
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            candIdx = PW'((int'(ptr) + k) % NREQ);
            if (!winFound && Req[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    // The shift register drains to zero after W shifts; gating with SOut keeps
    // D quiet outside SHIFT regardless.
    assign DOut = SOut & shreg[W-1];

    // Decoder clear covers every cycle reset is asserted (combinational term)
    // plus one registered cycle after release or after a timeout.
    assign DecClr = aR | decClrQ;

    always_ff @(posedge C) begin
        if (aR) begin
            state   <= IDLE;
            ptr     <= PW'(NREQ - 1);
            gIdx    <= '0;
            shreg   <= '0;
            cnt     <= '0;
            tmo     <= '0;
            Gnt     <= '0;
            Done    <= '0;
            Result  <= 1'b0;
            Err     <= 1'b0;
            SOut    <= 1'b0;
            Busy    <= 1'b0;
            decClrQ <= 1'b1;
        end else begin
            decClrQ <= 1'b0;
            Done    <= '0;
            case (state)
                IDLE: begin
                    if (winFound && DecQ == 2'd0) begin
                        state <= SHIFT;
                        gIdx  <= winIdx;
                        Gnt   <= NREQ'(1) << winIdx;
                        shreg <= words[winIdx];
                        cnt   <= '0;
                        SOut  <= 1'b1;
                        Busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= TERM;
                        SOut  <= 1'b0;
                    end
                end
                TERM: begin
                    if (RIn) begin
                        Result <= YIn;
                        Err    <= 1'b0;
                        Done   <= Gnt;
                        state  <= DONE;
                    end else begin
                        tmo   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A late R on the timeout cycle still counts as success.
                    if (RIn) begin
                        Result <= YIn;
                        Err    <= 1'b0;
                        Done   <= Gnt;
                        state  <= DONE;
                    end else if (tmo == 8'(TMO - 1)) begin
                        Result  <= 1'b0;
                        Err     <= 1'b1;
                        Done    <= Gnt;
                        decClrQ <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
                DONE: begin
                    ptr   <= gIdx;
                    Gnt   <= '0;
                    Err   <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Gnt   <= '0;
                    SOut  <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mealy_link_sched.sv
// Purpose: directed self-checking bench for mealy_link_sched (NREQ=4, W=4, TMO=8).
// Latency: inputs change away from the rising edge; outputs are sampled on the falling edge.
// Backpressure: the decoder side is a small reactive model driving R/Y at chosen cycles.
module tb_mealy_link_sched;

    logic        C;
    logic        aR;
    logic [3:0]  Req;
    logic [15:0] Word;
    logic [3:0]  Gnt;
    logic [3:0]  Done;
    logic        Result;
    logic        Err;
    logic        SOut;
    logic        DOut;
    logic        RIn;
    logic        YIn;
    logic [1:0]  DecQ;
    logic        DecClr;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    mealy_link_sched #(.NREQ(4), .W(4), .TMO(8)) dut (
        .C(C), .aR(aR), .Req(Req), .Word(Word), .Gnt(Gnt), .Done(Done),
        .Result(Result), .Err(Err), .SOut(SOut), .DOut(DOut), .RIn(RIn),
        .YIn(YIn), .DecQ(DecQ), .DecClr(DecClr), .Busy(Busy)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    typedef struct {
        logic        aR;
        logic [3:0]  req;
        logic [15:0] word;
        logic        rIn;
        logic        yIn;
        logic [1:0]  decQ;
        logic [3:0]  eGnt;
        logic [3:0]  eDone;
        logic        eRes;
        logic        eErr;
        logic        eS;
        logic        eD;
        logic        eClr;
        logic        eBusy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs one transaction from the current negedge. rDly: 0 = R in TERM,
    // k>0 = R in the k-th WAIT cycle, -1 = never. eAfter = WAIT cycles before DONE.
    task automatic txn(input string tag, input logic [3:0] req, input bit keep, input int rDly,
                       input logic y, input logic [3:0] eGnt, input int eAfter,
                       input logic eRes, input logic eErr, input logic eClr);
        int phase;
        int sCnt;
        int k;
        bit got;
        phase = 0; sCnt = 0; k = 0; got = 0;
        Req = req; RIn = 1'b0; YIn = y;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge C);
            RIn = 1'b0;
            chk({tag, ".gntOneHot"}, 32'($onehot0(Gnt)), 32'd1);
            if (Done != 4'd0) begin
                got = 1;
                chk({tag, ".Done"}, 32'(Done), 32'(eGnt));
                chk({tag, ".GntAtDone"}, 32'(Gnt), 32'(eGnt));
                chk({tag, ".Result"}, 32'(Result), 32'(eRes));
                chk({tag, ".Err"}, 32'(Err), 32'(eErr));
                chk({tag, ".DecClr"}, 32'(DecClr), 32'(eClr));
                chk({tag, ".waitCycles"}, 32'(k), 32'(eAfter));
                chk({tag, ".shiftLen"}, 32'(sCnt), 32'd4);
                if (!keep) Req = 4'd0;
            end else if (phase == 0) begin
                if (SOut) begin phase = 1; sCnt = 1; end
            end else if (phase == 1) begin
                if (SOut) sCnt++;
                else begin
                    phase = 2; k = 0;
                    RIn = (rDly == 0);
                    chk({tag, ".noClrTerm"}, 32'(DecClr), 32'd0);
                end
            end else begin
                k++;
                RIn = (rDly == k);
            end
        end
        chk({tag, ".doneSeen"}, 32'(got), 32'd1);
    endtask

    // Drops the request and answers R immediately, then expects Done to eGnt.
    task automatic finishTxn(input string tag, input logic [3:0] eGnt);
        bit got;
        got = 0;
        Req = 4'd0; RIn = 1'b1; YIn = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge C);
            if (Done != 4'd0) begin
                got = 1;
                chk({tag, ".Done"}, 32'(Done), 32'(eGnt));
            end
        end
        chk({tag, ".doneSeen"}, 32'(got), 32'd1);
        RIn = 1'b0;
    endtask

    initial begin
        bit seen;
        aR = 1'b1; Req = 4'd0; Word = 16'h0000; RIn = 1'b0; YIn = 1'b0; DecQ = 2'd0;

        // Single request, requester 0 word 1011, R with Y=1 in TERM.
        //           aR    req   word      r     y     dq     gnt   done  res   err   s     d     clr   busy
        vecs[0] = '{1'b1, 4'h0, 16'h5A4B, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 4'h0, 16'h5A4B, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 4'h1, 16'h5A4B, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 4'h1, 16'h5A4B, 1'b0, 1'b0, 2'd0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 4'h1, 16'h5A4B, 1'b0, 1'b0, 2'd0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 4'h1, 16'h5A4B, 1'b0, 1'b0, 2'd0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 4'h1, 16'h5A4B, 1'b0, 1'b0, 2'd0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 4'h1, 16'h5A4B, 1'b1, 1'b1, 2'd0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 4'h0, 16'h5A4B, 1'b0, 1'b0, 2'd0, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 4'h0, 16'h5A4B, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            @(posedge C);
            #1;
            aR = vecs[i].aR; Req = vecs[i].req; Word = vecs[i].word;
            RIn = vecs[i].rIn; YIn = vecs[i].yIn; DecQ = vecs[i].decQ;
            @(negedge C);
            chk($sformatf("vec%0d.Gnt", i),    32'(Gnt),    32'(vecs[i].eGnt));
            chk($sformatf("vec%0d.Done", i),   32'(Done),   32'(vecs[i].eDone));
            chk($sformatf("vec%0d.Result", i), 32'(Result), 32'(vecs[i].eRes));
            chk($sformatf("vec%0d.Err", i),    32'(Err),    32'(vecs[i].eErr));
            chk($sformatf("vec%0d.SOut", i),   32'(SOut),   32'(vecs[i].eS));
            chk($sformatf("vec%0d.DOut", i),   32'(DOut),   32'(vecs[i].eD));
            chk($sformatf("vec%0d.DecClr", i), 32'(DecClr), 32'(vecs[i].eClr));
            chk($sformatf("vec%0d.Busy", i),   32'(Busy),   32'(vecs[i].eBusy));
        end

        // Fresh reset so the pointer restarts at NREQ-1.
        aR = 1'b1;
        repeat (2) @(negedge C);
        aR = 1'b0;

        // Round-robin with all four requesting.
        txn("rr0", 4'hF, 1'b1, 0, 1'b1, 4'h1, 0, 1'b1, 1'b0, 1'b0);
        txn("rr1", 4'hF, 1'b1, 0, 1'b1, 4'h2, 0, 1'b1, 1'b0, 1'b0);
        txn("rr2", 4'hF, 1'b1, 0, 1'b1, 4'h4, 0, 1'b1, 1'b0, 1'b0);
        txn("rr3", 4'hF, 1'b1, 0, 1'b1, 4'h8, 0, 1'b1, 1'b0, 1'b0);
        txn("rr4", 4'hF, 1'b0, 0, 1'b1, 4'h1, 0, 1'b1, 1'b0, 1'b0);

        // Decoder silent: TERM plus 8 WAIT cycles, then error with DecClr.
        txn("tmo", 4'h2, 1'b0, -1, 1'b1, 4'h2, 8, 1'b0, 1'b1, 1'b1);
        @(negedge C);
        chk("tmo.clrAfter", 32'(DecClr), 32'd0);
        chk("tmo.gntAfter", 32'(Gnt), 32'd0);
        chk("tmo.busyAfter", 32'(Busy), 32'd0);

        // R in the first WAIT cycle, then late R (third WAIT cycle) with Y=0.
        txn("wait1", 4'h4, 1'b0, 1, 1'b1, 4'h4, 1, 1'b1, 1'b0, 1'b0);
        txn("lateR", 4'h1, 1'b0, 3, 1'b0, 4'h1, 3, 1'b0, 1'b0, 1'b0);

        // Reset in the second SHIFT cycle.
        Req = 4'b0110;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge C);
            if (SOut) seen = 1;
        end
        chk("rst.shiftSeen", 32'(seen), 32'd1);
        @(negedge C);
        aR = 1'b1;
        #1;
        chk("rst.clrComb", 32'(DecClr), 32'd1);
        @(negedge C);
        chk("rst.Gnt", 32'(Gnt), 32'd0);
        chk("rst.SOut", 32'(SOut), 32'd0);
        chk("rst.Busy", 32'(Busy), 32'd0);
        chk("rst.Done", 32'(Done), 32'd0);
        chk("rst.clr", 32'(DecClr), 32'd1);
        @(negedge C);
        aR = 1'b0; Req = 4'hF;
        #1;
        chk("rst.clrPlus1", 32'(DecClr), 32'd1);
        @(negedge C);
        chk("rst.clrOff", 32'(DecClr), 32'd0);
        chk("rst.firstGnt", 32'(Gnt), 32'h1);
        finishTxn("rst.fin", 4'h1);

        // Decoder not idle holds off the grant.
        Req = 4'h4; DecQ = 2'd2;
        for (int c = 0; c < 3; c++) begin
            @(negedge C);
            chk($sformatf("decq.hold%0d.Gnt", c), 32'(Gnt), 32'd0);
            chk($sformatf("decq.hold%0d.Busy", c), 32'(Busy), 32'd0);
        end
        DecQ = 2'd0;
        @(negedge C);
        chk("decq.Gnt", 32'(Gnt), 32'h4);
        finishTxn("decq.fin", 4'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
